// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared constants and types for the hazard scoreboard
//
// Purpose: register-file geometry, the bank-select enum and the default
// branch flush length used by hazard_scoreboard and flush_counter.
package hazard_scoreboard_pkg;

  localparam int IDX_W              = 4;
  localparam int NREGS              = 16;
  localparam int BRANCH_PENALTY_DEF = 2;

  // Wide enough for any branch penalty in 1..7.
  localparam int FLUSH_CNT_W = 3;

  typedef enum logic {
    BANK_SCALAR = 1'b0,
    BANK_VECTOR = 1'b1
  } bank_e;

endpackage

// File: rtl/hazard_scoreboard_flush_counter.sv
// rtl/hazard_scoreboard_flush_counter.sv - loadable down-counter driving the branch flush
//
// Purpose: loads a penalty value when a branch issues and counts down to zero,
// one step per clock. nonzero_o is high while the count is not zero.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   load_i     in   load load_val_i this edge
//   load_val_i in   value to load (CNT_W bits)
//   nonzero_o  out  count != 0
module flush_counter #(
  parameter int CNT_W = hazard_scoreboard_pkg::FLUSH_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             nonzero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW/WAW register scoreboard with branch flush control
//
// Purpose: tracks one pending-write bit per register in a scalar and a vector
// bank, stalls ID on RAW/WAW hazards and flushes for BRANCH_PENALTY cycles
// after a branch issues.
// Optional feature: define HAZARD_WB_BYPASS_EN so that a source being written
// back in the same cycle does not raise RAW (bank writes before it is read).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   id_valid                    instruction present in ID
//   id_ra, id_rb, id_rc         source A, source B, destination index
//   id_use_ra, id_use_rb        source A / B is read
//   id_mode_sel                 sources from vector bank (1) or scalar bank (0)
//   id_reg_write(_v)            writes scalar / vector bank
//   id_branch                   instruction is a branch
//   wb_we_s, wb_we_v, wb_rd     writeback enables and destination
//   stall, flush                pipeline hold / bubble insert
//   busy_s, busy_v              pending bits per bank
module hazard_scoreboard #(
  parameter int NREGS          = hazard_scoreboard_pkg::NREGS,
  parameter int IDX_W          = hazard_scoreboard_pkg::IDX_W,
  parameter int BRANCH_PENALTY = hazard_scoreboard_pkg::BRANCH_PENALTY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [IDX_W-1:0] id_ra,
  input  logic [IDX_W-1:0] id_rb,
  input  logic [IDX_W-1:0] id_rc,
  input  logic             id_use_ra,
  input  logic             id_use_rb,
  input  logic             id_mode_sel,
  input  logic             id_reg_write,
  input  logic             id_reg_write_v,
  input  logic             id_branch,
  input  logic             wb_we_s,
  input  logic             wb_we_v,
  input  logic [IDX_W-1:0] wb_rd,
  output logic             stall,
  output logic             flush,
  output logic [NREGS-1:0] busy_s,
  output logic [NREGS-1:0] busy_v
);
  import hazard_scoreboard_pkg::*;

  localparam logic [FLUSH_CNT_W-1:0] PENALTY_VAL = FLUSH_CNT_W'(BRANCH_PENALTY);

  logic [NREGS-1:0] busy_s_q, busy_s_d;
  logic [NREGS-1:0] busy_v_q, busy_v_d;
  logic [NREGS-1:0] wb_clr_s, wb_clr_v;
  logic [NREGS-1:0] set_s, set_v;
  logic [NREGS-1:0] src_pend_s, src_pend_v, src_pend;
  bank_e            src_bank;
  logic             raw, waw, issue;

  // One-hot writeback clear masks; both banks may clear in the same cycle.
  always_comb begin
    wb_clr_s = '0;
    wb_clr_v = '0;
    if (wb_we_s) wb_clr_s[wb_rd] = 1'b1;
    if (wb_we_v) wb_clr_v[wb_rd] = 1'b1;
  end

  // Pending view seen by source operands.
`ifdef HAZARD_WB_BYPASS_EN
  assign src_pend_s = busy_s_q & ~wb_clr_s;
  assign src_pend_v = busy_v_q & ~wb_clr_v;
`else
  assign src_pend_s = busy_s_q;
  assign src_pend_v = busy_v_q;
`endif

  assign src_bank = id_mode_sel ? BANK_VECTOR : BANK_SCALAR;
  assign src_pend = (src_bank == BANK_VECTOR) ? src_pend_v : src_pend_s;

  assign raw = (id_use_ra & src_pend[id_ra]) | (id_use_rb & src_pend[id_rb]);
  // WAW always looks at the registered bits: a writeback in this cycle does
  // not let a new writer of the same register issue early.
  assign waw = (id_reg_write & busy_s_q[id_rc]) | (id_reg_write_v & busy_v_q[id_rc]);

  assign stall = id_valid & ~flush & (raw | waw);
  assign issue = id_valid & ~stall & ~flush;

  always_comb begin
    set_s = '0;
    set_v = '0;
    if (issue & id_reg_write)   set_s[id_rc] = 1'b1;
    if (issue & id_reg_write_v) set_v[id_rc] = 1'b1;
    // Set is applied after clear so an issuing writer wins over writeback.
    busy_s_d = (busy_s_q & ~wb_clr_s) | set_s;
    busy_v_d = (busy_v_q & ~wb_clr_v) | set_v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_s_q <= '0;
      busy_v_q <= '0;
    end else begin
      busy_s_q <= busy_s_d;
      busy_v_q <= busy_v_d;
    end
  end

  assign busy_s = busy_s_q;
  assign busy_v = busy_v_q;

  flush_counter #(
    .CNT_W(FLUSH_CNT_W)
  ) u_flush_counter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (issue & id_branch),
    .load_val_i(PENALTY_VAL),
    .nonzero_o (flush)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int NR  = 16;
  localparam int IW  = 4;
  localparam int PEN = 2;
`ifdef HAZARD_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_ra, id_use_rb, id_mode_sel;
  logic id_reg_write, id_reg_write_v, id_branch;
  logic [IW-1:0] id_ra, id_rb, id_rc, wb_rd;
  logic wb_we_s, wb_we_v;
  logic stall, flush;
  logic [NR-1:0] busy_s, busy_v;

  int total = 0;
  int bad   = 0;

  // Reference model: set of pending registers per bank and flush cycles left.
  logic [NR-1:0] m_s, m_v;
  int            m_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_ra         (id_ra),
    .id_rb         (id_rb),
    .id_rc         (id_rc),
    .id_use_ra     (id_use_ra),
    .id_use_rb     (id_use_rb),
    .id_mode_sel   (id_mode_sel),
    .id_reg_write  (id_reg_write),
    .id_reg_write_v(id_reg_write_v),
    .id_branch     (id_branch),
    .wb_we_s       (wb_we_s),
    .wb_we_v       (wb_we_v),
    .wb_rd         (wb_rd),
    .stall         (stall),
    .flush         (flush),
    .busy_s        (busy_s),
    .busy_v        (busy_v)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic instr(input bit v, input int ra, input int rb, input int rc,
                       input bit ua, input bit ub, input bit mode,
                       input bit wr, input bit wrv, input bit br);
    id_valid = v; id_ra = IW'(ra); id_rb = IW'(rb); id_rc = IW'(rc);
    id_use_ra = ua; id_use_rb = ub; id_mode_sel = mode;
    id_reg_write = wr; id_reg_write_v = wrv; id_branch = br;
  endtask

  task automatic wb(input bit s, input bit v, input int rd);
    wb_we_s = s; wb_we_v = v; wb_rd = IW'(rd);
  endtask

  task automatic idle();
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
  endtask

  task automatic model_reset();
    m_s = '0; m_v = '0; m_cnt = 0;
  endtask

  // Is source idx visible as pending, given the bank and this cycle's writeback?
  function automatic bit src_pend(input logic [IW-1:0] idx, input bit vec);
    bit p;
    bit clearing;
    p = vec ? m_v[idx] : m_s[idx];
    clearing = vec ? (wb_we_v && wb_rd == idx) : (wb_we_s && wb_rd == idx);
    if (BYPASS && clearing) p = 1'b0;
    return p;
  endfunction

  // Called at a negedge with inputs applied: check outputs, advance the model
  // across the next rising edge, return at the following negedge.
  task automatic cycle();
    bit ef, es, raw, waw, iss;
    #1;
    ef  = (m_cnt != 0);
    raw = (id_use_ra && src_pend(id_ra, id_mode_sel)) ||
          (id_use_rb && src_pend(id_rb, id_mode_sel));
    waw = (id_reg_write && m_s[id_rc]) || (id_reg_write_v && m_v[id_rc]);
    es  = id_valid && !ef && (raw || waw);
    check("stall", {31'd0, stall}, {31'd0, es});
    check("flush", {31'd0, flush}, {31'd0, ef});
    check("busy_s", {16'd0, busy_s}, {16'd0, m_s});
    check("busy_v", {16'd0, busy_v}, {16'd0, m_v});
    iss = id_valid && !es && !ef;
    if (wb_we_s) m_s[wb_rd] = 1'b0;
    if (wb_we_v) m_v[wb_rd] = 1'b0;
    if (iss && id_reg_write)   m_s[id_rc] = 1'b1;
    if (iss && id_reg_write_v) m_v[id_rc] = 1'b1;
    if (m_cnt > 0) m_cnt--;
    if (iss && id_branch) m_cnt = PEN;
    @(negedge clk);
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    #3;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_busy_s", {16'd0, busy_s}, 32'd0);
    check("rst_busy_v", {16'd0, busy_v}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Scalar RAW on R3 resolved by scalar writeback.
    instr(1, 0, 0, 3, 0, 0, 0, 1, 0, 0); cycle();
    instr(1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
    #1 check("raw_r3_stall", {31'd0, stall}, 32'd1);
    cycle();
    wb(1, 0, 3);
    #1 check("raw_r3_wb_cycle", {31'd0, stall}, BYPASS ? 32'd0 : 32'd1);
    cycle();
    wb(0, 0, 0);
    #1 check("raw_r3_after_wb", {31'd0, stall}, 32'd0);
    cycle();
    idle();

    // Vector V5 pending does not block a scalar read of R5.
    instr(1, 0, 0, 5, 0, 0, 0, 0, 1, 0); cycle();
    instr(1, 5, 5, 0, 1, 1, 0, 0, 0, 0);
    #1 check("v5_scalar_read", {31'd0, stall}, 32'd0);
    cycle();
    idle(); wb(0, 1, 5); cycle(); idle();

    // Branch flush of exactly PEN cycles suppresses stall.
    instr(1, 0, 0, 9, 0, 0, 0, 1, 0, 0); cycle();
    instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    instr(1, 9, 0, 0, 1, 0, 0, 0, 0, 0);
    #1 check("flush_c1", {30'd0, flush, stall}, 32'd2);
    cycle();
    #1 check("flush_c2", {30'd0, flush, stall}, 32'd2);
    cycle();
    #1 check("flush_end", {30'd0, flush, stall}, 32'd1);
    cycle();
    idle(); wb(1, 0, 9); cycle(); idle();

    // Issue to R7 coincides with its writeback: set wins.
    instr(1, 0, 0, 7, 0, 0, 0, 1, 0, 0); wb(1, 0, 7); cycle();
    idle();
    #1 check("set_wins_r7", {31'd0, busy_s[7]}, 32'd1);
    for (int r = 4; r < 7; r++) begin
      instr(1, 0, 0, r, 0, 0, 0, 1, 0, 0); cycle();
    end
    instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    instr(1, 4, 0, 4, 1, 0, 0, 1, 0, 0);
    #1 check("pre_rst_state", {15'd0, flush, busy_s}, {15'd0, 1'b1, 16'h00F0});
    rst = 1'b1;
    #1;
    check("async_rst_busy_s", {16'd0, busy_s}, 32'd0);
    check("async_rst_flush", {31'd0, flush}, 32'd0);
    check("async_rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 check("post_rst_no_hazard", {31'd0, stall}, 32'd0);
    cycle();
    idle(); wb(1, 0, 4); cycle(); idle();

    // WAW on R2 with R2 and V2 pending; dual writeback clears both.
    instr(1, 0, 0, 2, 0, 0, 0, 1, 1, 0); cycle();
    instr(1, 0, 0, 2, 0, 0, 0, 1, 0, 0);
    #1 check("waw_stall", {31'd0, stall}, 32'd1);
    cycle();
    wb(1, 1, 2);
    #1 check("waw_wb_cycle", {31'd0, stall}, 32'd1);
    cycle();
    wb(0, 0, 0);
    #1 check("waw_issue", {29'd0, stall, busy_s[2], busy_v[2]}, 32'd0);
    cycle();
    idle();
    #1 check("waw_reissued", {30'd0, busy_s[2], busy_v[2]}, 32'd2);
    wb(1, 0, 2); cycle(); idle();

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      instr($urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0);
      wb($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREGS, default 16, is the number of registers per bank (scalar bank and vector bank).
REQ-002 Parameter IDX_W, default 4, is the register index width; NREGS SHALL equal 2**IDX_W.
REQ-003 Parameter BRANCH_PENALTY, default 2, is the number of flush cycles after a branch issues (range 1..7).
REQ-004 clk  input  1  pipeline clock, all state rising-edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 id_valid  input  1  a decoded instruction is present in ID this cycle.
REQ-007 id_ra, id_rb, id_rc  input  IDX_W each  source A, source B, destination index (inst[21:18], [17:14], [25:22]).
REQ-008 id_use_ra, id_use_rb  input  1 each  the instruction reads source A / source B.
REQ-009 id_mode_sel  input  1  sources read from the vector bank when 1, scalar bank when 0.
REQ-010 id_reg_write, id_reg_write_v  input  1 each  instruction writes the scalar / vector bank.
REQ-011 id_branch  input  1  instruction is a branch.
REQ-012 wb_we_s, wb_we_v  input  1 each  writeback write enables (WE1, WE2).
REQ-013 wb_rd  input  IDX_W  writeback destination index (Rd).
REQ-014 stall  output  1  hold IF/ID and PC; drives ID_EX en low.
REQ-015 flush  output  1  insert bubble; drives ID_EX buffer reset.
REQ-016 busy_s, busy_v  output  NREGS each  current scalar / vector pending bits.

Function
REQ-017 The block SHALL keep one pending bit per register per bank, and the bit SHALL be set at the clock edge where a writing instruction issues (id_valid & !stall & !flush & write flag).
REQ-018 A pending bit SHALL clear at the clock edge where the matching wb_we_* is high for wb_rd.
REQ-019 When set and clear target the same bit in one cycle, set SHALL win.
REQ-020 stall SHALL be combinational: id_valid & !flush & (RAW | WAW).
REQ-021 RAW SHALL be true when a used source is pending in the bank selected by id_mode_sel.
REQ-022 WAW SHALL be true when the destination is pending in a bank the instruction writes.
REQ-023 An issuing id_branch SHALL load the flush counter with BRANCH_PENALTY; flush SHALL be high while counter != 0, and the counter SHALL decrement once per cycle.
REQ-024 While flush is high, ID instructions SHALL NOT issue, set pending bits or load the counter; writeback clears SHALL continue.
REQ-025 A stalled instruction SHALL issue in the first cycle its hazard clears, so stall has zero added latency beyond the hazard.
REQ-026 Only the vector bank SHALL change on a vector-bank write, and only the scalar bank on a scalar-bank write; a simultaneous wb_we_s and wb_we_v SHALL clear both bits.

Reset
REQ-027 While rst is high, all pending bits, the flush counter, stall and flush SHALL be 0, independent of clk.
REQ-028 Reset mid-stall or mid-flush SHALL abandon the stall or flush; the first post-reset cycle SHALL see no hazards.

Configuration
REQ-029 With macro HAZARD_WB_BYPASS_EN defined, a source whose pending bit is being cleared by writeback in the same cycle SHALL NOT raise RAW, because the register bank writes before it is read.
REQ-030 Without HAZARD_WB_BYPASS_EN, that case SHALL stall one additional cycle.

Structure
REQ-031 A shared package SHALL hold IDX_W, NREGS, the bank-select enum (BANK_SCALAR, BANK_VECTOR) and the default branch penalty constant.
REQ-032 One sub-module, flush_counter, SHALL implement the loadable down-counter and its nonzero output.

Verification
REQ-033 Issue scalar write to R3, then a scalar read of R3 next cycle -> stall=1 until wb_we_s with wb_rd=3; with HAZARD_WB_BYPASS_EN, stall=0 in the WB cycle, otherwise stall clears one cycle later.
REQ-034 Vector write to V5 pending, then a scalar read of R5 (id_mode_sel=0) -> stall=0.
REQ-035 Issue a branch with BRANCH_PENALTY=2 -> flush=1 for exactly 2 cycles; a hazardous instruction during the flush -> stall=0.
REQ-036 Issue of a write to R7 coinciding with wb_we_s for R7 -> busy_s[7]=1 after the edge.
REQ-037 Assert rst during a flush with busy_s=16'h00F0 -> busy_s=0, flush=0 and stall=0 immediately, without waiting for a clock edge.
REQ-038 Pending writes to R2 and V2, then a WAW write to R2 -> stall=1; wb_we_s=wb_we_v=1 with wb_rd=2 -> both bits clear and the instruction issues.
